// File: rtl/essential_bit_scheduler.sv
// essential_bit_scheduler: walks the set bits of an 8-bit weight mask MSB-first,
// one handshaken beat per essential bit; an all-zero mask yields a single zero-flagged beat.
`default_nettype none

module essential_bit_scheduler (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_mask,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_idx,
    output logic       out_last,
    output logic       out_zero,
    output logic       busy,
    output logic [3:0] beat_cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] rem_mask;
    logic [7:0] rem_mask_nxt;
    logic [3:0] beat_cnt_nxt;
    logic [2:0] lead_idx;
    logic [7:0] lead_bit;
    logic       single;
    logic       in_fire;
    logic       out_fire;

    // Ascending scan: the highest set bit is written last and wins.
    always_comb begin
        lead_idx = 3'd0;
        lead_bit = 8'd0;
        for (int i = 0; i < 8; i++) begin
            if (rem_mask[i]) begin
                lead_idx = 3'(7 - i);
                lead_bit = 8'd1 << i;
            end
        end
    end

    assign single    = (rem_mask & (rem_mask - 8'd1)) == 8'd0;
    assign out_valid = (state == RUN);
    assign busy      = (state == RUN);
    assign out_idx   = lead_idx;
    assign out_last  = single;
    assign out_zero  = (state == RUN) && (rem_mask == 8'd0);
    assign in_ready  = (state == IDLE) || (out_ready && single);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_nxt    = state;
        rem_mask_nxt = rem_mask;
        beat_cnt_nxt = beat_cnt;
        // Clearing the leading one of a single-bit mask drains it to zero,
        // so the idle state naturally presents idx 0 / last 1.
        if (out_fire) begin
            rem_mask_nxt = rem_mask & ~lead_bit;
            beat_cnt_nxt = beat_cnt + 4'd1;
            if (single) begin
                state_nxt = IDLE;
            end
        end
        if (in_fire) begin
            rem_mask_nxt = in_mask;
            beat_cnt_nxt = 4'd0;
            state_nxt    = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rem_mask <= 8'd0;
            beat_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            rem_mask <= rem_mask_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_essential_bit_scheduler.sv
// Self-checking bench for essential_bit_scheduler: table vectors, directed corner
// sequences, and randomized traffic against a queue-based reference model.
`default_nettype none

module tb_essential_bit_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_mask;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic       out_last;
    logic       out_zero;
    logic       busy;
    logic [3:0] beat_cnt;

    essential_bit_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_zero  (out_zero),
        .busy      (busy),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the pending beats as a queue of MSB-first indices.
    int q[$];
    bit act = 1'b0;
    int cnt = 0;

    typedef struct {
        logic [7:0] mask;
        int         beats;
        int         first_idx;
        int         last_idx;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_cmp++;
        if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act_v, exp_v, $time);
        end
    endtask

    // Apply inputs, let combinational outputs settle, compare everything to the model.
    task automatic setin(input logic iv, input logic [7:0] m, input logic ordy);
        bit m_last;
        in_valid  = iv;
        in_mask   = m;
        out_ready = ordy;
        #1;
        m_last = (q.size() <= 1);
        chk("out_valid", 32'(out_valid), 32'(act));
        chk("busy", 32'(busy), 32'(act));
        chk("out_idx", 32'(out_idx), (q.size() > 0) ? 32'(q[0]) : 32'd0);
        chk("out_last", 32'(out_last), 32'(m_last));
        chk("out_zero", 32'(out_zero), 32'(act && q.size() == 0));
        chk("beat_cnt", 32'(beat_cnt), 32'(cnt));
        chk("in_ready", 32'(in_ready), 32'(!act || (ordy && m_last)));
    endtask

    task automatic tick();
        bit m_last;
        bit infire;
        bit outfire;
        m_last  = (q.size() <= 1);
        infire  = in_valid && (!act || (out_ready && m_last));
        outfire = act && out_ready;
        @(posedge clk);
        #1;
        if (reset) begin
            q.delete();
            act = 1'b0;
            cnt = 0;
        end else begin
            if (outfire) begin
                if (q.size() > 0) void'(q.pop_front());
                cnt++;
                if (m_last) act = 1'b0;
            end
            if (infire) begin
                q.delete();
                for (int b = 7; b >= 0; b--) if (in_mask[b]) q.push_back(7 - b);
                cnt = 0;
                act = 1'b1;
            end
        end
    endtask

    initial begin
        vecs[0] = '{8'hA1, 3, 0, 7};
        vecs[1] = '{8'h00, 1, 0, 0};
        vecs[2] = '{8'h03, 2, 6, 7};
        vecs[3] = '{8'h80, 1, 0, 0};
        vecs[4] = '{8'hFF, 8, 0, 7};
        vecs[5] = '{8'h01, 1, 7, 7};
        vecs[6] = '{8'h10, 1, 3, 3};
        vecs[7] = '{8'h5A, 4, 1, 6};

        reset = 1'b1; in_valid = 1'b1; in_mask = 8'hFF; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete(); act = 1'b0; cnt = 0;

        // Reset state
        setin(0, 8'h00, 0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        tick();

        // Table vectors
        for (int v = 0; v < 8; v++) begin
            int n;
            int first;
            int lst;
            bit done;
            setin(1, vecs[v].mask, 1);
            tick();
            n = 0; first = -1; lst = -1; done = 0;
            while (!done && n < 20) begin
                setin(0, 8'h00, 1);
                if (n == 0) first = int'(out_idx);
                lst  = int'(out_idx);
                done = out_valid && out_last;
                n++;
                tick();
            end
            chk("tbl_done", 32'(done), 32'd1);
            chk("tbl_beats", 32'(n), 32'(vecs[v].beats));
            chk("tbl_first_idx", 32'(first), 32'(vecs[v].first_idx));
            chk("tbl_last_idx", 32'(lst), 32'(vecs[v].last_idx));
            setin(0, 8'h00, 0);
            chk("tbl_cnt_after", 32'(beat_cnt), 32'(vecs[v].beats));
        end

        // 1010_0001 MSB-first walk
        setin(1, 8'hA1, 1); tick();
        setin(0, 8'h00, 1); chk("a1_idx0", 32'(out_idx), 32'd0); chk("a1_last0", 32'(out_last), 32'd0); tick();
        setin(0, 8'h00, 1); chk("a1_idx1", 32'(out_idx), 32'd2); chk("a1_last1", 32'(out_last), 32'd0); tick();
        setin(0, 8'h00, 1); chk("a1_idx2", 32'(out_idx), 32'd7); chk("a1_last2", 32'(out_last), 32'd1);
        chk("a1_in_ready", 32'(in_ready), 32'd1); tick();
        setin(0, 8'h00, 1); chk("a1_cnt", 32'(beat_cnt), 32'd3); chk("a1_idle", 32'(out_valid), 32'd0);

        // All-zero mask emits one zero-flagged beat
        setin(1, 8'h00, 1); tick();
        setin(0, 8'h00, 1); chk("z_zero", 32'(out_zero), 32'd1); chk("z_last", 32'(out_last), 32'd1); tick();
        setin(0, 8'h00, 1); chk("z_cnt", 32'(beat_cnt), 32'd1); chk("z_busy", 32'(busy), 32'd0);

        // Backpressure holds outputs
        setin(1, 8'h03, 0); tick();
        for (int k = 0; k < 3; k++) begin
            setin(0, 8'h00, 0); chk("bp_idx_hold", 32'(out_idx), 32'd6); chk("bp_last_hold", 32'(out_last), 32'd0); tick();
        end
        setin(0, 8'h00, 1); chk("bp_idx6", 32'(out_idx), 32'd6); tick();
        setin(0, 8'h00, 1); chk("bp_idx7", 32'(out_idx), 32'd7); chk("bp_last7", 32'(out_last), 32'd1); tick();

        // Back-to-back masks with no bubble
        setin(1, 8'h80, 1); tick();
        setin(1, 8'h01, 1); chk("b2b_idx0", 32'(out_idx), 32'd0); chk("b2b_ready", 32'(in_ready), 32'd1); tick();
        setin(0, 8'h00, 1); chk("b2b_valid", 32'(out_valid), 32'd1); chk("b2b_idx7", 32'(out_idx), 32'd7);
        chk("b2b_cnt", 32'(beat_cnt), 32'd0); tick();

        // Full mask, then reset mid-mask
        setin(1, 8'hFF, 1); tick();
        for (int k = 0; k < 8; k++) begin
            setin(0, 8'h00, 1); chk("ff_idx", 32'(out_idx), 32'(k)); chk("ff_last", 32'(out_last), 32'(k == 7)); tick();
        end
        setin(0, 8'h00, 0); chk("ff_cnt", 32'(beat_cnt), 32'd8);
        setin(1, 8'hFF, 1); tick();
        for (int k = 0; k < 3; k++) begin setin(0, 8'h00, 1); tick(); end
        reset = 1'b1;
        setin(1, 8'h0F, 1); tick();
        reset = 1'b0;
        setin(0, 8'h00, 0);
        chk("rr_valid", 32'(out_valid), 32'd0); chk("rr_busy", 32'(busy), 32'd0);
        chk("rr_ready", 32'(in_ready), 32'd1); chk("rr_cnt", 32'(beat_cnt), 32'd0);
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic [7:0] m;
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0) m = 8'h00;
            else if (sel < 3) m = 8'd1 << $urandom_range(0, 7);
            else m = 8'($urandom);
            reset = ($urandom_range(0, 199) == 0);
            setin(($urandom_range(0, 1) == 1), m, ($urandom_range(0, 9) < 7));
            tick();
            reset = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
